// File: rtl/dcache_load_unit.sv
// Load side of a direct-mapped, write-through data cache with one-word lines.
// Misses refill from RAM over a req/valid handshake; results are byte/half/word extended.
module dcache_load_unit #(
  parameter int WIDTH = 32,
  parameter int SETS  = 8,
  parameter int IDX   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic             lw,
  input  logic             lh,
  input  logic             lb,
  input  logic             uns,
  input  logic [WIDTH-1:0] addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_valid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall,
  output logic             ld_done,
  output logic [WIDTH-1:0] dout
);

  localparam int TAGW = WIDTH - IDX - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]  valid;
  logic [TAGW-1:0]  tags [SETS];
  logic [WIDTH-1:0] data [SETS];

  // Load type and byte offset captured at miss time, used when the refill returns.
  logic       lw_q, lh_q, lb_q, uns_q;
  logic [1:0] off_q;

  logic [IDX-1:0]  ld_idx, wr_idx, fill_idx;
  logic [TAGW-1:0] ld_tag, wr_tag, fill_tag;
  logic            ld_hit, wr_hit;

  // Byte offset of a store is irrelevant: the update word is already merged.
  logic unused_wr_off;
  assign unused_wr_off = ^wr_addr[1:0];

  assign ld_idx   = addr[IDX+1:2];
  assign ld_tag   = addr[WIDTH-1:IDX+2];
  assign wr_idx   = wr_addr[IDX+1:2];
  assign wr_tag   = wr_addr[WIDTH-1:IDX+2];
  assign fill_idx = mem_addr[IDX+1:2];
  assign fill_tag = mem_addr[WIDTH-1:IDX+2];

  assign ld_hit = valid[ld_idx] && (tags[ld_idx] == ld_tag);
  assign wr_hit = valid[wr_idx] && (tags[wr_idx] == wr_tag);

  function automatic logic [WIDTH-1:0] extract(
    input logic [WIDTH-1:0] w,
    input logic             f_lw,
    input logic             f_lh,
    input logic             f_lb,
    input logic             f_uns,
    input logic [1:0]       off
  );
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    if (f_lw)      return w;
    else if (f_lh) return {{(WIDTH-16){~f_uns & h[15]}}, h};
    else if (f_lb) return {{(WIDTH-8){~f_uns & b[7]}}, b};
    else           return '0;
  endfunction

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (ld_req && !ld_hit) begin
          stall     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        stall = 1'b1;
        if (mem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ld_done  <= 1'b0;
      dout     <= '0;
    end else begin
      state   <= state_nxt;
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_req) begin
            if (ld_hit) begin
              ld_done <= 1'b1;
              dout    <= extract(data[ld_idx], lw, lh, lb, uns, addr[1:0]);
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {addr[WIDTH-1:2], 2'b00};
            end
          end
        end
        FETCH: begin
          if (mem_valid) begin
            valid[fill_idx] <= 1'b1;
            mem_req         <= 1'b0;
            ld_done         <= 1'b1;
            dout            <= extract(mem_rdata, lw_q, lh_q, lb_q, uns_q, off_q);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag/data arrays and miss flags are not reset; the valid bits alone
  // qualify them, which keeps the arrays plain RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_req && !ld_hit) begin
      lw_q  <= lw;
      lh_q  <= lh;
      lb_q  <= lb;
      uns_q <= uns;
      off_q <= addr[1:0];
    end
    if (state == FETCH && mem_valid) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem_rdata;
    end else if (state == IDLE && wr_en && wr_hit) begin
      data[wr_idx] <= wr_data;
    end
  end

endmodule
